// File: rtl/ql_memory_bank_bl_wl_ctrl.sv
// Bitline/wordline programming controller for memory-bank routing tiles:
// loads one bitline frame per row, then pulses that row's wordline with programmable setup/pulse widths.
module ql_memory_bank_bl_wl_ctrl #(
  parameter int BL_WIDTH = 6,
  parameter int WL_WIDTH = 6,
  parameter int WL_SETUP = 1,
  parameter int WL_PULSE = 2
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [0:BL_WIDTH-1] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [0:BL_WIDTH-1] bl,
  output logic [0:WL_WIDTH-1] wl,
  output logic                busy,
  output logic                done
);

  localparam int ROW_W  = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
  localparam int TMAX   = (WL_SETUP > WL_PULSE) ? WL_SETUP : WL_PULSE;
  localparam int TCNT_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [ROW_W-1:0]    LAST_ROW   = ROW_W'(WL_WIDTH - 1);
  localparam logic [TCNT_W-1:0]   SETUP_LAST = TCNT_W'(WL_SETUP - 1);
  localparam logic [TCNT_W-1:0]   PULSE_LAST = TCNT_W'(WL_PULSE - 1);
  // wl[0] is the MSB of the ascending range, so shifting right by row selects wl[row].
  localparam logic [0:WL_WIDTH-1] WL_FIRST   = WL_WIDTH'(1) << (WL_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ROW_W-1:0]    r_row;
  logic [TCNT_W-1:0]   r_tcnt;
  logic [0:BL_WIDTH-1] r_bl;
  logic [0:WL_WIDTH-1] r_wl;
  logic [0:WL_WIDTH-1] w_wl_sel;
  logic                w_bl_load;
  logic                w_tcnt_clr;
  logic                w_tcnt_inc;
  logic                w_row_clr;
  logic                w_row_inc;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_bl_load    = 1'b0;
    w_tcnt_clr   = 1'b0;
    w_tcnt_inc   = 1'b0;
    w_row_clr    = 1'b0;
    w_row_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_LOAD;
          w_row_clr    = 1'b1;
        end
      end
      S_LOAD: begin
        if (din_valid) begin
          w_next_state = S_SETUP;
          w_bl_load    = 1'b1;
          w_tcnt_clr   = 1'b1;
        end
      end
      S_SETUP: begin
        if (r_tcnt == SETUP_LAST) begin
          w_next_state = S_PULSE;
          w_tcnt_clr   = 1'b1;
        end else begin
          w_tcnt_inc   = 1'b1;
        end
      end
      S_PULSE: begin
        if (r_tcnt == PULSE_LAST) begin
          w_next_state = S_HOLD;
        end else begin
          w_tcnt_inc   = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_row == LAST_ROW) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_LOAD;
          w_row_inc    = 1'b1;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    // Cancel wins over both a new start and a completing handshake.
    if (abort) begin
      w_next_state = S_IDLE;
      w_bl_load    = 1'b0;
      w_tcnt_clr   = 1'b0;
      w_tcnt_inc   = 1'b0;
      w_row_clr    = 1'b0;
      w_row_inc    = 1'b0;
    end
  end

  assign w_wl_sel = WL_FIRST >> r_row;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_row  <= '0;
      r_tcnt <= '0;
      r_bl   <= '0;
      r_wl   <= '0;
    end else begin
      if (w_row_clr) begin
        r_row <= '0;
      end else if (w_row_inc) begin
        r_row <= r_row + ROW_W'(1);
      end
      if (w_tcnt_clr) begin
        r_tcnt <= '0;
      end else if (w_tcnt_inc) begin
        r_tcnt <= r_tcnt + TCNT_W'(1);
      end
      if (w_bl_load) begin
        r_bl <= din;
      end
      // Wordline is high exactly while the state register holds PULSE; row is stable across it.
      r_wl <= (w_next_state == S_PULSE) ? w_wl_sel : '0;
    end
  end

  assign bl        = r_bl;
  assign wl        = r_wl;
  assign din_ready = (r_state == S_LOAD);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_ql_memory_bank_bl_wl_ctrl.sv
// Bench for ql_memory_bank_bl_wl_ctrl: row-schedule model compared every cycle, plus literal timeline checks.
`timescale 1ns/1ps
module tb_ql_memory_bank_bl_wl_ctrl;
  localparam int N  = 6;
  localparam int BW = 6;
  localparam int S  = 1;
  localparam int P  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, din_valid = 1'b0;
  logic [0:BW-1] din = '0;
  logic          din_ready, busy, done;
  logic [0:BW-1] bl;
  logic [0:N-1]  wl;

  logic          s_start = 1'b0, s_abort = 1'b0, s_din_valid = 1'b0;
  logic [0:BW-1] s_din = '0;
  logic          s_din_ready, s_busy, s_done;
  logic [0:BW-1] s_bl;
  logic [0:0]    s_wl;

  always #5 clk = ~clk;

  ql_memory_bank_bl_wl_ctrl #(.BL_WIDTH(BW), .WL_WIDTH(N), .WL_SETUP(S), .WL_PULSE(P)) dut (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start), .abort(abort),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .bl(bl), .wl(wl), .busy(busy), .done(done));

  ql_memory_bank_bl_wl_ctrl #(.BL_WIDTH(BW), .WL_WIDTH(1), .WL_SETUP(3), .WL_PULSE(1)) dut_sw (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(s_start), .abort(s_abort),
    .din(s_din), .din_valid(s_din_valid), .din_ready(s_din_ready),
    .bl(s_bl), .wl(s_wl), .busy(s_busy), .done(s_done));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [0:N-1] oh(input int r);
    logic [0:N-1] v;
    v    = '0;
    v[0] = 1'b1;
    return v >> r;
  endfunction

  logic [0:BW-1] frames [0:7];
  initial begin
    frames[0] = 6'b101010; frames[1] = 6'b010101; frames[2] = 6'b111111;
    frames[3] = 6'b000000; frames[4] = 6'b110011; frames[5] = 6'b001100;
    frames[6] = 6'b000000; frames[7] = 6'b000000;
  end

  // Model: a pass is a list of rows; after a frame is accepted the row is timed by
  // k = cycles since acceptance: setup k=1..S, pulse S+1..S+P, hold S+P+1, done S+P+2.
  typedef enum {M_IDLE, M_LOAD, M_TIMED} mmode_t;
  mmode_t        m_mode = M_IDLE;
  int            m_k = 0;
  int            m_row = 0;
  logic [0:BW-1] m_bl = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_k = 0; m_row = 0; m_bl = '0;
    end else if (abort) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin m_mode = M_LOAD; m_row = 0; end
        M_LOAD: if (din_valid) begin m_bl = din; m_mode = M_TIMED; m_k = 1; end
        default: begin
          if (m_k == S + P + 1) begin
            if (m_row == N - 1) m_k++;
            else begin m_row++; m_mode = M_LOAD; end
          end else if (m_k == S + P + 2) begin
            m_mode = M_IDLE;
          end else begin
            m_k++;
          end
        end
      endcase
    end
  end

  int cyc = 0;
  int t0  = 1000000;
  always @(posedge clk) cyc <= cyc + 1;

  logic          chk_en = 1'b0;
  logic          log_en = 1'b0;
  logic [0:N-1]  ob_wl   [0:63];
  logic [0:BW-1] ob_bl   [0:63];
  logic          ob_done [0:63];
  logic          ob_busy [0:63];
  logic          ob_rdy  [0:63];
  logic          sw_wl   [0:63];
  logic [0:BW-1] sw_bl   [0:63];
  logic          sw_done [0:63];
  logic          sw_busy [0:63];
  logic          sw_rdy  [0:63];

  always @(negedge clk) begin
    int rel;
    logic [0:N-1] e_wl;
    if (chk_en) begin
      e_wl = (m_mode == M_TIMED && m_k > S && m_k <= S + P) ? oh(m_row) : '0;
      check("wl",        64'(wl),        64'(e_wl));
      check("bl",        64'(bl),        64'(m_bl));
      check("busy",      64'(busy),      64'(m_mode != M_IDLE));
      check("din_ready", 64'(din_ready), 64'(m_mode == M_LOAD));
      check("done",      64'(done),      64'(m_mode == M_TIMED && m_k == S + P + 2));
    end
    rel = cyc - t0 + 1;
    if (log_en && rel >= 0 && rel < 64) begin
      ob_wl[6'(rel)] = wl;     ob_bl[6'(rel)] = bl;     ob_done[6'(rel)] = done;
      ob_busy[6'(rel)] = busy; ob_rdy[6'(rel)] = din_ready;
      sw_wl[6'(rel)] = s_wl[0]; sw_bl[6'(rel)] = s_bl;  sw_done[6'(rel)] = s_done;
      sw_busy[6'(rel)] = s_busy; sw_rdy[6'(rel)] = s_din_ready;
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < 64; i++) begin
      ob_wl[6'(i)] = '0; ob_bl[6'(i)] = '0; ob_done[6'(i)] = 1'b0; ob_busy[6'(i)] = 1'b0; ob_rdy[6'(i)] = 1'b0;
      sw_wl[6'(i)] = 1'b0; sw_bl[6'(i)] = '0; sw_done[6'(i)] = 1'b0; sw_busy[6'(i)] = 1'b0; sw_rdy[6'(i)] = 1'b0;
    end
  endtask

  // Drives one pass on the main instance; cycle k is the k-th cycle after the start edge.
  task automatic main_pass(input int ncyc, input int stall_from, input int stall_len,
                           input int abort_at, input int restart_at, input int rst_at);
    int   fidx;
    logic prev_hs;
    logic stop;
    clear_logs();
    @(negedge clk);
    start = 1'b1; din = frames[0]; din_valid = 1'b1; t0 = cyc + 1; log_en = 1'b1;
    fidx = 0; prev_hs = 1'b0; stop = 1'b0;
    for (int k = 1; k <= ncyc && !stop; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      abort = (k == abort_at);
      if (prev_hs && fidx < N - 1) fidx++;
      din       = frames[3'(fidx)];
      din_valid = !(k >= stall_from && k < stall_from + stall_len);
      prev_hs   = din_ready && din_valid;
      if (k == rst_at) begin
        check("rst_pre_wl", 64'(wl), 64'(oh(1)));
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_wl",   64'(wl),        64'd0);
        check("rst_async_bl",   64'(bl),        64'd0);
        check("rst_async_busy", 64'(busy),      64'd0);
        check("rst_async_rdy",  64'(din_ready), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        stop = 1'b1;
      end
    end
    start = 1'b0; abort = 1'b0; din_valid = 1'b0; log_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [0:N-1] e;
    repeat (3) @(negedge clk);
    check("reset_bl",   64'(bl),        64'd0);
    check("reset_wl",   64'(wl),        64'd0);
    check("reset_rdy",  64'(din_ready), 64'd0);
    check("reset_busy", 64'(busy),      64'd0);
    check("reset_done", 64'(done),      64'd0);
    check("reset_sw_wl", 64'(s_wl),     64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Full pass with a stray start during row 1 and din_valid left high through SETUP/PULSE.
    main_pass(34, 100, 0, 0, 8, 0);
    check("p1_rdy_c1", 64'(ob_rdy[1]), 64'd1);
    for (int r = 1; r <= 33; r++) begin
      e = (r >= 3 && r <= 29 && ((r - 3) % 5) < 2) ? oh((r - 3) / 5) : '0;
      check("p1_wl_timeline", 64'(ob_wl[6'(r)]), 64'(e));
      if (e != '0) check("p1_bl_in_pulse", 64'(ob_bl[6'(r)]), 64'(frames[3'((r - 3) / 5)]));
      check("p1_done_timeline", 64'(ob_done[6'(r)]), 64'(r == 31));
    end
    check("p1_busy_c31", 64'(ob_busy[31]), 64'd1);
    check("p1_busy_c32", 64'(ob_busy[32]), 64'd0);

    // Source stalls four cycles before row 2.
    main_pass(38, 11, 4, 0, 0, 0);
    for (int r = 11; r <= 15; r++) check("p2_rdy_stall", 64'(ob_rdy[6'(r)]), 64'd1);
    check("p2_wl_c16", 64'(ob_wl[16]), 64'd0);
    check("p2_wl_c17", 64'(ob_wl[17]), 64'(oh(2)));
    check("p2_wl_c18", 64'(ob_wl[18]), 64'(oh(2)));
    check("p2_wl_c19", 64'(ob_wl[19]), 64'd0);
    for (int r = 1; r <= 36; r++) check("p2_done_timeline", 64'(ob_done[6'(r)]), 64'(r == 35));

    // Abort in the first pulse cycle of row 3.
    main_pass(25, 100, 0, 18, 0, 0);
    check("p3_wl_c18",   64'(ob_wl[18]),   64'(oh(3)));
    check("p3_wl_c19",   64'(ob_wl[19]),   64'd0);
    check("p3_busy_c19", 64'(ob_busy[19]), 64'd0);
    check("p3_bl_held",  64'(ob_bl[20]),   64'(frames[3]));
    for (int r = 1; r <= 24; r++) check("p3_no_done", 64'(ob_done[6'(r)]), 64'd0);

    // A fresh start after the abort programs from row 0.
    main_pass(34, 100, 0, 0, 0, 0);
    check("p4_wl_c3",   64'(ob_wl[3]),   64'(oh(0)));
    check("p4_bl_c3",   64'(ob_bl[3]),   64'(frames[0]));
    check("p4_done_c31", 64'(ob_done[31]), 64'd1);

    // Asynchronous reset in the first pulse cycle of row 1.
    main_pass(20, 100, 0, 0, 0, 8);

    // Single-row sweep instance: setup 3, pulse 1.
    clear_logs();
    @(negedge clk);
    s_start = 1'b1; s_din = 6'b101101; s_din_valid = 1'b1; t0 = cyc + 1; log_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      s_start = 1'b0;
    end
    s_din_valid = 1'b0; log_en = 1'b0;
    check("sw_rdy_c1", 64'(sw_rdy[1]), 64'd1);
    for (int r = 1; r <= 8; r++) begin
      check("sw_wl_timeline",   64'(sw_wl[6'(r)]),   64'(r == 5));
      check("sw_done_timeline", 64'(sw_done[6'(r)]), 64'(r == 7));
    end
    check("sw_bl_c5",   64'(sw_bl[5]),   64'(6'b101101));
    check("sw_busy_c6", 64'(sw_busy[6]), 64'd1);
    check("sw_busy_c8", 64'(sw_busy[8]), 64'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
